// File: rtl/addsub_arbiter_pkg.sv
// addsub_pkg: shared types for the add/sub arbiter slice.
// Holds op codes, FSM states and the operand width.
package addsub_pkg;

   localparam int OPW = 4;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_EXEC = 2'b01,
      S_DONE = 2'b10
   } state_e;

endpackage

// File: rtl/addsub_arbiter_if.sv
// addsub_arbiter_if: request, response and shared-unit bus.
// slave = the arbiter block, master = requesters/consumer/unit.
interface addsub_arbiter_if
   import addsub_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);

   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [OPW*NREQ-1:0] req_a;
   logic [OPW*NREQ-1:0] req_b;
   logic [2*NREQ-1:0]   req_op;

   logic                rsp_valid;
   logic                rsp_ready;
   logic [IDW-1:0]      rsp_id;
   logic [OPW-1:0]      rsp_res;

   logic [OPW-1:0]      unit_a;
   logic [OPW-1:0]      unit_b;
   logic [1:0]          unit_sign;
   logic [OPW-1:0]      unit_res;

   modport slave (
      input  req_valid, req_a, req_b, req_op,
      input  rsp_ready, unit_res,
      output req_ready, rsp_valid, rsp_id, rsp_res,
      output unit_a, unit_b, unit_sign
   );

   modport master (
      output req_valid, req_a, req_b, req_op,
      output rsp_ready, unit_res,
      input  req_ready, rsp_valid, rsp_id, rsp_res,
      input  unit_a, unit_b, unit_sign
   );

endinterface

// File: rtl/addsub_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
// Ports: i_req, i_ptr, i_en in; o_gnt (one-hot), o_idx out.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDW-1:0]  i_ptr,
   input  logic            i_en,
   output logic [NREQ-1:0] o_gnt,
   output logic [IDW-1:0]  o_idx
);

   logic           w_found;
   logic [IDW-1:0] w_cand;

   // Scan ptr+1, ptr+2, ... wrapping at NREQ; first hit wins.
   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_cand  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         w_cand = IDW'((int'(i_ptr) + k) % NREQ);
         if (i_en && !w_found && i_req[w_cand]) begin
            w_found       = 1'b1;
            o_gnt[w_cand] = 1'b1;
            o_idx         = w_cand;
         end
      end
   end

endmodule

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: shares one add/sub unit among NREQ requesters.
// Ports: clk, rst_n, en in; busy out; bus = addsub_arbiter_if.slave.
module addsub_arbiter
   import addsub_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   output logic           busy,
   addsub_arbiter_if.slave bus
);

   state_e          r_state;
   state_e          w_next;
   logic [IDW-1:0]  r_ptr;
   logic [IDW-1:0]  r_id;
   logic [IDW-1:0]  w_idx;
   logic [NREQ-1:0] w_gnt;
   logic [OPW-1:0]  r_unit_a;
   logic [OPW-1:0]  r_unit_b;
   logic [1:0]      r_unit_sign;
   logic [OPW-1:0]  r_rsp_res;
   logic [OPW-1:0]  w_sel_a;
   logic [OPW-1:0]  w_sel_b;
   logic [1:0]      w_sel_op;
   logic            w_arb_en;
   logic            w_hs;

   // rst_n gates grants so req_ready stays low during reset.
   assign w_arb_en = rst_n & en & (r_state == S_IDLE);

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .i_req (bus.req_valid),
      .i_ptr (r_ptr),
      .i_en  (w_arb_en),
      .o_gnt (w_gnt),
      .o_idx (w_idx)
   );

   assign w_hs = |(bus.req_valid & w_gnt);

   // One-hot grant drives an AND-OR operand mux.
   always_comb begin
      w_sel_a  = '0;
      w_sel_b  = '0;
      w_sel_op = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_gnt[i]) begin
            w_sel_a  = bus.req_a[OPW*i +: OPW];
            w_sel_b  = bus.req_b[OPW*i +: OPW];
            w_sel_op = bus.req_op[2*i +: 2];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_hs) begin
               w_next = S_EXEC;
            end
         end
         S_EXEC: begin
            w_next = S_DONE;
         end
         S_DONE: begin
            if (bus.rsp_ready) begin
               w_next = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr       <= IDW'(NREQ - 1);
         r_id        <= '0;
         r_unit_a    <= '0;
         r_unit_b    <= '0;
         r_unit_sign <= '0;
         r_rsp_res   <= '0;
      end else begin
         if ((r_state == S_IDLE) && w_hs) begin
            r_unit_a    <= w_sel_a;
            r_unit_b    <= w_sel_b;
            r_unit_sign <= w_sel_op;
            r_ptr       <= w_idx;
            r_id        <= w_idx;
         end
         if (r_state == S_EXEC) begin
            r_rsp_res <= bus.unit_res;
         end
      end
   end

   assign bus.req_ready = w_gnt;
   assign bus.rsp_valid = (r_state == S_DONE);
   assign bus.rsp_id    = r_id;
   assign bus.rsp_res   = r_rsp_res;
   assign bus.unit_a    = r_unit_a;
   assign bus.unit_b    = r_unit_b;
   assign bus.unit_sign = r_unit_sign;
   assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: directed bench with a cycle model
// and a response scoreboard for addsub_arbiter.
module tb_addsub_arbiter;

   typedef struct packed {
      logic [1:0] id;
      logic [3:0] res;
   } exp_t;

   logic clk;
   logic rst_n;
   logic en;
   logic busy;

   addsub_arbiter_if #(.NREQ(4), .IDW(2)) bus ();

   addsub_arbiter #(
      .NREQ (4),
      .IDW  (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .busy  (busy),
      .bus   (bus)
   );

   // Stand-in for the external signed_addsub_4 unit.
   assign bus.unit_res = (bus.unit_sign == 2'b01) ?
                         bus.unit_a - bus.unit_b :
                         bus.unit_a + bus.unit_b;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_checks;
   int   n_fail;
   int   cyc_n;
   int   n_rsp;
   int   m_state;
   logic [1:0] m_ptr;
   exp_t sb[$];
   int   g_id[$];
   int   g_cyc[$];
   int   r_cyc;
   logic [1:0] last_id;
   logic [3:0] last_res;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] rr(input logic [3:0] v,
                                     input logic [1:0] p);
      logic [3:0] g;
      bit         f;
      int         c;
      g = '0;
      f = 0;
      for (int k = 1; k <= 4; k++) begin
         c = (int'(p) + k) % 4;
         if (!f && v[c]) begin
            g[c] = 1'b1;
            f    = 1;
         end
      end
      return g;
   endfunction

   function automatic logic [3:0] calc(input logic [3:0] a,
                                       input logic [3:0] b,
                                       input logic [1:0] op);
      return (op == 2'b01) ? a - b : a + b;
   endfunction

   task automatic set_req(input int i, input logic [3:0] a,
                          input logic [3:0] b,
                          input logic [1:0] op);
      bus.req_a[4*i +: 4] = a;
      bus.req_b[4*i +: 4] = b;
      bus.req_op[2*i +: 2] = op;
   endtask

   // One clock: sample at negedge, step model at posedge.
   task automatic cyc();
      logic [3:0] er;
      int         nxt;
      int         idx;
      exp_t       e;
      @(negedge clk);
      cyc_n++;
      er = (rst_n && en && m_state == 0) ?
           rr(bus.req_valid, m_ptr) : 4'b0;
      chk("req_ready", 32'(bus.req_ready), 32'(er));
      chk("busy", 32'(busy), 32'(m_state != 0));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_state == 2));
      nxt = m_state;
      if (m_state == 0 && |(er & bus.req_valid)) begin
         idx = 0;
         for (int i = 0; i < 4; i++) begin
            if (er[i]) idx = i;
         end
         e.id  = 2'(idx);
         e.res = calc(bus.req_a[4*idx +: 4],
                      bus.req_b[4*idx +: 4],
                      bus.req_op[2*idx +: 2]);
         sb.push_back(e);
         m_ptr = 2'(idx);
         g_id.push_back(idx);
         g_cyc.push_back(cyc_n);
         nxt = 1;
      end else if (m_state == 1) begin
         nxt = 2;
      end else if (m_state == 2) begin
         chk("sb_depth", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            chk("rsp_id", 32'(bus.rsp_id), 32'(sb[0].id));
            chk("rsp_res", 32'(bus.rsp_res), 32'(sb[0].res));
            if (bus.rsp_ready) begin
               last_id  = sb[0].id;
               last_res = sb[0].res;
               void'(sb.pop_front());
               n_rsp++;
               r_cyc = cyc_n;
               nxt   = 0;
            end
         end
      end
      @(posedge clk);
      if (rst_n) m_state = nxt;
      #1;
   endtask

   // Asynchronous reset: checked immediately, released
   // one time unit after a rising edge.
   task automatic do_reset(input int n);
      rst_n   = 1'b0;
      m_state = 0;
      m_ptr   = 2'd3;
      sb.delete();
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_unit_a", 32'(bus.unit_a), 32'd0);
      chk("rst_unit_b", 32'(bus.unit_b), 32'd0);
      chk("rst_unit_sign", 32'(bus.unit_sign), 32'd0);
      chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
      chk("rst_rsp_res", 32'(bus.rsp_res), 32'd0);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
      end
      #1;
      chk("rst_hold_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_hold_ready", 32'(bus.req_ready), 32'd0);
      rst_n = 1'b1;
   endtask

   task automatic run_one(input int i, input logic [3:0] a,
                          input logic [3:0] b,
                          input logic [1:0] op);
      int start;
      start = n_rsp;
      set_req(i, a, b, op);
      bus.req_valid[i] = 1'b1;
      cyc();
      bus.req_valid[i] = 1'b0;
      for (int k = 0; k < 10 && n_rsp == start; k++) begin
         cyc();
      end
      chk("rsp_timeout", 32'(n_rsp != start), 32'd1);
   endtask

   int n_g;
   int n_r;

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      cyc_n         = 0;
      n_rsp         = 0;
      r_cyc         = 0;
      last_id       = '0;
      last_res      = '0;
      m_state       = 0;
      m_ptr         = 2'd3;
      en            = 1'b0;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_op    = '0;
      bus.rsp_ready = 1'b0;
      rst_n         = 1'b1;
      #2;
      do_reset(3);

      // Single add on requester 0.
      en            = 1'b1;
      bus.rsp_ready = 1'b1;
      run_one(0, 4'd3, 4'd4, 2'b00);
      chk("single_id", 32'(last_id), 32'd0);
      chk("single_res", 32'(last_res), 32'h7);
      chk("single_lat", 32'(r_cyc - g_cyc[$]), 32'd2);
      chk("hold_unit_a", 32'(bus.unit_a), 32'd3);
      chk("hold_unit_b", 32'(bus.unit_b), 32'd4);
      chk("hold_unit_sign", 32'(bus.unit_sign), 32'd0);

      // Subtract with wrap, then add that overflows.
      run_one(2, 4'd2, 4'd5, 2'b01);
      chk("sub_id", 32'(last_id), 32'd2);
      chk("sub_res", 32'(last_res), 32'hD);
      run_one(1, 4'd7, 4'd1, 2'b00);
      chk("ovf_id", 32'(last_id), 32'd1);
      chk("ovf_res", 32'(last_res), 32'h8);

      // Round robin with all requesters pending.
      do_reset(2);
      g_id.delete();
      g_cyc.delete();
      set_req(0, 4'd1, 4'd2, 2'b00);
      set_req(1, 4'd9, 4'd3, 2'b01);
      set_req(2, 4'd6, 4'd6, 2'b00);
      set_req(3, 4'd0, 4'd1, 2'b01);
      bus.rsp_ready = 1'b1;
      bus.req_valid = 4'b1111;
      for (int k = 0; k < 15; k++) cyc();
      bus.req_valid = 4'b0000;
      for (int k = 0; k < 4; k++) cyc();
      chk("rr_count", 32'(g_id.size()), 32'd5);
      if (g_id.size() >= 5) begin
         chk("rr_g0", 32'(g_id[0]), 32'd0);
         chk("rr_g1", 32'(g_id[1]), 32'd1);
         chk("rr_g2", 32'(g_id[2]), 32'd2);
         chk("rr_g3", 32'(g_id[3]), 32'd3);
         chk("rr_g4", 32'(g_id[4]), 32'd0);
         for (int k = 0; k < 4; k++) begin
            chk("rr_gap", 32'(g_cyc[k+1] - g_cyc[k]), 32'd3);
         end
      end

      // Backpressure in DONE.
      bus.rsp_ready = 1'b0;
      bus.req_valid = 4'b1001;
      cyc();
      cyc();
      for (int k = 0; k < 5; k++) cyc();
      chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_busy", 32'(busy), 32'd1);
      n_r = n_rsp;
      bus.rsp_ready = 1'b1;
      cyc();
      chk("bp_retire", 32'(n_rsp - n_r), 32'd1);
      bus.rsp_ready = 1'b0;
      cyc();
      bus.req_valid = 4'b0000;
      bus.rsp_ready = 1'b1;
      for (int k = 0; k < 3; k++) cyc();

      // Enable gating.
      en            = 1'b0;
      bus.req_valid = 4'b1111;
      n_g = g_id.size();
      for (int k = 0; k < 3; k++) cyc();
      chk("en_no_grant", 32'(g_id.size()), 32'(n_g));
      en  = 1'b1;
      n_r = n_rsp;
      cyc();
      en = 1'b0;
      for (int k = 0; k < 6; k++) cyc();
      chk("en_one_grant", 32'(g_id.size() - n_g), 32'd1);
      chk("en_one_rsp", 32'(n_rsp - n_r), 32'd1);

      // Reset during EXEC.
      en = 1'b1;
      n_r = n_rsp;
      cyc();
      chk("mid_busy_pre", 32'(busy), 32'd1);
      do_reset(2);
      cyc();
      chk("post_rst_grant", 32'(g_id[$]), 32'd0);
      bus.req_valid = 4'b0000;
      for (int k = 0; k < 6; k++) cyc();
      chk("post_rst_rsp", 32'(n_rsp - n_r), 32'd1);
      chk("post_rst_id", 32'(last_id), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
